// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet layout, port index type and merge-slot states.
package noc_pkg;

  localparam int unsigned NOC_W   = 9;
  localparam int unsigned ADDR_HI = 8;
  localparam int unsigned ADDR_LO = 5;

  typedef logic [NOC_W-1:0] noc_pkt_t;

  // Branch index: 0 = In0, 1 = In1.
  typedef logic port_sel_t;

  // Output slot occupancy, encoded as {out_pend, s_pend}.
  typedef enum logic [1:0] {
    SLOT_EMPTY    = 2'b00,
    SLOT_OUT_DONE = 2'b01,
    SLOT_S_DONE   = 2'b10,
    SLOT_FULL     = 2'b11
  } slot_state_t;

  // Address field of a packet.
  function automatic logic [ADDR_HI-ADDR_LO:0] pkt_addr(input noc_pkt_t p);
    return p[ADDR_HI:ADDR_LO];
  endfunction

endpackage

// File: rtl/arbiter13_leaf_rr_arb2.sv
// Two-request round-robin arbiter. Grants are combinational; the priority
// pointer moves to the losing index whenever en_i signals a taken grant.
module rr_arb2
  import noc_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      req0_i,
  input  logic      req1_i,
  input  logic      en_i,
  output logic      gnt0_o,
  output logic      gnt1_o,
  output port_sel_t prio_o
);

  port_sel_t prio_q;
  port_sel_t prio_d;

  // Grant the sole requester, or the favoured one when both request.
  always_comb begin
    gnt0_o = req0_i & (~req1_i | ~prio_q);
    gnt1_o = req1_i & (~req0_i | prio_q);
    // Loser becomes favoured: after an In0 win the pointer goes to 1.
    prio_d = en_i ? port_sel_t'(gnt0_o) : prio_q;
    prio_o = prio_q;
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= RR_INIT;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/arbiter13_leaf.sv
// Two-input merge leaf: round-robin picks one packet per cycle into a single
// output slot that drains independently on the data and winner-record channels.
module arbiter13_leaf
  import noc_pkg::*;
#(
  parameter int unsigned W       = NOC_W,
  parameter logic        RR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in0_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  input  logic [W-1:0] in1_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         s_valid,
  input  logic         s_ready,
  output logic         s_data
);

  slot_state_t state_q;
  slot_state_t state_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  port_sel_t    win_q;
  port_sel_t    win_d;

  logic out_pend;
  logic s_pend;
  logic out_hs;
  logic s_hs;
  logic free;
  logic gnt0;
  logic gnt1;
  logic xfer;
  port_sel_t prio_unused;

  rr_arb2 #(
    .RR_INIT(RR_INIT)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0_i (in0_valid),
    .req1_i (in1_valid),
    .en_i   (xfer),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1),
    .prio_o (prio_unused)
  );

  // Slot occupancy, handshakes and input acceptance.
  always_comb begin
    out_pend  = state_q[1];
    s_pend    = state_q[0];
    out_hs    = out_pend & out_ready;
    s_hs      = s_pend & s_ready;
    free      = (~out_pend | out_ready) & (~s_pend | s_ready);
    in0_ready = free & gnt0;
    in1_ready = free & gnt1;
    xfer      = in0_ready | in1_ready;
  end

  // Next slot contents: a new grant refills both channels, otherwise each
  // channel clears on its own handshake.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    win_d   = win_q;
    if (xfer) begin
      state_d = SLOT_FULL;
      data_d  = gnt1 ? in1_data : in0_data;
      win_d   = port_sel_t'(gnt1);
    end else begin
      unique case (state_q)
        SLOT_FULL: begin
          if (out_hs && s_hs) state_d = SLOT_EMPTY;
          else if (out_hs)    state_d = SLOT_OUT_DONE;
          else if (s_hs)      state_d = SLOT_S_DONE;
          else                state_d = SLOT_FULL;
        end
        SLOT_S_DONE:   state_d = out_hs ? SLOT_EMPTY : SLOT_S_DONE;
        SLOT_OUT_DONE: state_d = s_hs ? SLOT_EMPTY : SLOT_OUT_DONE;
        default:       state_d = SLOT_EMPTY;
      endcase
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      win_q   <= win_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    out_valid = state_q[1];
    s_valid   = state_q[0];
    out_data  = data_q;
    s_data    = win_q;
  end

endmodule

// File: tb/tb_arbiter13_leaf.sv
// Scoreboard bench for arbiter13_leaf: a driver predicts grants from the
// round-robin rules and queues expected packets; a monitor checks transfers.
module tb_arbiter13_leaf;
  import noc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, v1, ordy, srdy;
  logic [8:0] d0, d1;
  logic       in0_ready, in1_ready, out_valid, s_valid, s_data;
  logic [8:0] out_data;

  arbiter13_leaf #(.W(9), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(v0), .in0_ready(in0_ready), .in0_data(d0),
    .in1_valid(v1), .in1_ready(in1_ready), .in1_data(d1),
    .out_valid(out_valid), .out_ready(ordy), .out_data(out_data),
    .s_valid(s_valid), .s_ready(srdy), .s_data(s_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: pending flags per channel, favoured input.
  logic [8:0] qo[$];
  int         qs[$];
  bit         m_out, m_s;
  int         fav;
  int         last_g;
  int         gcnt[2];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    qo.delete();
    qs.delete();
    m_out = 0;
    m_s   = 0;
    fav   = 0;
  endtask

  // Called at posedge+1: apply inputs, predict at negedge, advance to next posedge+1.
  task automatic cyc(input logic a0, input logic [8:0] a0d, input logic a1,
                     input logic [8:0] a1d, input logic o_r, input logic s_r);
    bit f;
    v0 = a0; d0 = a0d; v1 = a1; d1 = a1d; ordy = o_r; srdy = s_r;
    @(negedge clk);
    f = (!m_out || o_r) && (!m_s || s_r);
    last_g = -1;
    if (f) begin
      if (a0 && a1) last_g = fav;
      else if (a0)  last_g = 0;
      else if (a1)  last_g = 1;
    end
    chk("out_valid", int'(out_valid), int'(m_out));
    chk("s_valid", int'(s_valid), int'(m_s));
    chk("in0_ready", int'(in0_ready), int'(last_g == 0));
    chk("in1_ready", int'(in1_ready), int'(last_g == 1));
    if (last_g >= 0) begin
      qo.push_back(last_g == 1 ? a1d : a0d);
      qs.push_back(last_g);
      m_out = 1;
      m_s   = 1;
      fav   = 1 - last_g;
      gcnt[last_g]++;
    end else begin
      if (o_r) m_out = 0;
      if (s_r) m_s = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer on an output channel must match the queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && ordy) begin
        if (qo.size() == 0) chk("out_unexpected", 1, 0);
        else chk("out_data", int'(out_data), int'(qo.pop_front()));
      end
      if (s_valid && srdy) begin
        if (qs.size() == 0) chk("s_unexpected", 1, 0);
        else chk("s_data", int'(s_data), qs.pop_front());
      end
    end
  end

  initial begin
    int g0, prev;
    logic [8:0] hold;
    rst_n = 1'b0;
    v0 = 0; v1 = 0; d0 = '0; d1 = '0; ordy = 0; srdy = 0;
    gcnt[0] = 0; gcnt[1] = 0;
    model_reset();
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_s_valid", int'(s_valid), 0);
    chk("rst_in0_ready", int'(in0_ready), 0);
    chk("rst_in1_ready", int'(in1_ready), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_s_data", int'(s_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset while a packet is held: it is discarded and the pointer returns to In0.
    cyc(1, 9'h1A5, 0, 9'h000, 0, 0);
    v0 = 0; ordy = 0; srdy = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_s_valid", int'(s_valid), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1, 9'h033, 1, 9'h144, 1, 1);
    chk("prio_after_reset", last_g, 0);
    cyc(0, 9'h000, 0, 9'h000, 1, 1);

    // Single active input.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 9'h000, 1, 9'(9'h180 + i), 1, 1);
      chk("single_in1_win", last_g, 1);
    end
    cyc(0, 9'h000, 0, 9'h000, 1, 1);

    // Dual saturation: strict alternation and an even split.
    gcnt[0] = 0; gcnt[1] = 0; prev = -1;
    for (int i = 0; i < 100; i++) begin
      cyc(1, 9'h0AA, 1, 9'h155, 1, 1);
      if (prev >= 0) chk("sat_alternate", int'(last_g != prev), 1);
      prev = last_g;
    end
    chk("sat_in0_share", gcnt[0], 50);
    chk("sat_in1_share", gcnt[1], 50);
    cyc(0, 9'h000, 0, 9'h000, 1, 1);

    // Split drain: record drains first, data channel stalls and blocks In1.
    cyc(1, 9'h1F0, 0, 9'h000, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 9'h000, 1, 9'h0F1, 0, 1);
      chk("split_no_grant", last_g, -1);
      chk("split_out_data", int'(out_data), 9'h1F0);
    end
    cyc(0, 9'h000, 1, 9'h0F1, 1, 1);
    chk("split_release_grant", last_g, 1);
    cyc(0, 9'h000, 0, 9'h000, 1, 1);

    // Stall then burst.
    cyc(1, 9'h011, 1, 9'h122, 1, 1);
    g0 = last_g;
    hold = (g0 == 1) ? 9'h122 : 9'h011;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 9'h011, 1, 9'h122, 0, 1);
      chk("stall_no_grant", last_g, -1);
      chk("stall_out_data", int'(out_data), int'(hold));
    end
    cyc(1, 9'h011, 1, 9'h122, 1, 1);
    chk("stall_loser_first", last_g, 1 - g0);
    cyc(0, 9'h000, 0, 9'h000, 1, 1);

    // Idle-skip fairness: In1 wins the first contended cycle after In0-only traffic.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 9'(9'h040 + i), 0, 9'h000, 1, 1);
      chk("idle_in0_win", last_g, 0);
    end
    cyc(1, 9'h050, 1, 9'h160, 1, 1);
    chk("idle_skip_in1", last_g, 1);

    // Random traffic; a producer holds its packet until it is accepted.
    v0 = 0; v1 = 0;
    for (int i = 0; i < 2000; i++) begin
      logic n0, n1;
      logic [8:0] nd0, nd1;
      n0 = v0; nd0 = d0; n1 = v1; nd1 = d1;
      if (!(v0 && last_g != 0)) begin
        n0 = ($urandom % 3) != 0; nd0 = 9'($urandom_range(0, 511));
      end
      if (!(v1 && last_g != 1)) begin
        n1 = ($urandom % 3) != 0; nd1 = 9'($urandom_range(0, 511));
      end
      cyc(n0, nd0, n1, nd1, ($urandom % 4) != 0, ($urandom % 4) != 0);
    end

    // Drain and confirm nothing is left outstanding.
    for (int i = 0; i < 4; i++) cyc(0, 9'h000, 0, 9'h000, 1, 1);
    chk("drain_out_queue", qo.size(), 0);
    chk("drain_s_queue", qs.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arbiter13_leaf.md
# arbiter13_leaf

Clocked two-input merge leaf for the NoC return path: the counterpart of the decoder leaf, which splits one 9-bit packet stream onto two branches. This block merges two 9-bit packet streams back onto one. It also emits a 1-bit winner record per packet on a separate select channel. Round-robin arbitration keeps either branch from starving the other. One registered output slot gives one packet per cycle sustained throughput.

## Interface
- `W`, 9, packet width. Bits [8:5] are the address; [4:0] are the payload. The block passes all bits through unmodified.
- `RR_INIT`, 0, priority pointer value after reset (0 means In0 is favoured).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in0_valid`  in  1  In0 holds a packet.
- `in0_ready`  out  1  In0 packet accepted this cycle when high together with `in0_valid`.
- `in0_data`  in  W  In0 packet.
- `in1_valid`, `in1_ready`, `in1_data`  in/out/in  1/1/W  same as In0, for In1.
- `out_valid`  out  1  merged packet available.
- `out_ready`  in  1  downstream takes the packet.
- `out_data`  out  W  merged packet.
- `s_valid`  out  1  winner record available.
- `s_ready`  in  1  consumer takes the record.
- `s_data`  out  1  winning input index: 0 = In0, 1 = In1.

## Operation
- Handshake rule for all ports: a transfer occurs on a rising edge where valid=1 and ready=1.
  - Once asserted, `out_valid` and `s_valid` stay high with stable data until their own transfer.
  - Producers on In0/In1 obey the same rule; the block does not check this.
- Output slot:
  - One register holds {data, winner}.
  - Flags `out_pend` and `s_pend` track it.
  - `out_valid = out_pend`; `s_valid = s_pend`.
  - The two output channels drain independently, in either order or the same cycle.
- Slot free this cycle: `free = (!out_pend | out_ready) & (!s_pend | s_ready)`.
- Grant, combinational, gated by `free`:
  - Only In0 valid: grant In0.
  - Only In1 valid: grant In1.
  - Both valid: grant the input selected by pointer `prio`.
  - `in0_ready = free & grant0`; `in1_ready = free & grant1`. At most one ready is high per cycle.
- On a granted transfer:
  - Load the slot with the winner's data and index.
  - Set both `out_pend` and `s_pend`.
  - Set `prio` to the loser's index (the other input). This applies even when the other input was idle.
- Without a transfer:
  - Clear `out_pend` on out handshake.
  - Clear `s_pend` on s handshake.
  - `prio` holds.
- States, derived from the flags: EMPTY (0,0), FULL (1,1), S_DONE (1,0), OUT_DONE (0,1).
  - FULL→EMPTY when both handshakes occur in the same cycle, or FULL→EMPTY→FULL when a new grant also occurs that cycle.
  - S_DONE→EMPTY on out handshake.
  - OUT_DONE→EMPTY on s handshake.
  - No grant while in S_DONE or OUT_DONE unless the remaining handshake completes that same cycle.

## Timing
- Reset, asynchronous: `out_pend=0`, `s_pend=0`, `prio=RR_INIT`, slot data=0.
  - All outputs are low: `out_valid`, `s_valid`, `in0_ready`, `in1_ready`, `out_data=0`, `s_data=0`.
  - Reset during a pending packet discards that packet.
  - The first grant can happen on the first edge after `rst_n` deasserts.
- Latency: input accept edge N gives `out_valid`/`s_valid` high after edge N, so data are visible in cycle N+1.
- Throughput: with `out_ready` and `s_ready` held high, one packet per cycle. Under dual load, grants alternate In0, In1, In0, ...
- Ready depends combinationally on `out_ready`/`s_ready`. There is no path from valid to valid.
- Back-pressure on either output channel alone stalls both inputs.

## Structure
- Shared package `noc_pkg` holds:
  - `NOC_W=9`, `ADDR_HI=8`, `ADDR_LO=5`
  - typedef `noc_pkt_t` (logic [8:0])
  - typedef `port_sel_t` (logic, 0/1)
- The package is shared with the decoder leaf and the tree-level modules.
- Sub-module `rr_arb2`: two requests, `prio` register, update enable, grant outputs. It is reused by wider arbiter trees.
- The top level holds the slot register and the pend flags.

## Test plan
- Reset mid-packet: load 0x1A5 from In0, hold `out_ready=0`, pulse `rst_n` low → `out_valid=0` and `s_valid=0` immediately; `prio=0` after release.
- Single input: In1 sends 0x180, 0x181, 0x182 with outputs always ready → `out_data` gives the same sequence one cycle after each accept, `s_data=1` each time, `in0_ready=0` throughout.
- Dual saturation: both inputs valid continuously (In0=0x0AA, In1=0x155), outputs ready → winners 0,1,0,1,... one per cycle; each input gets 50% of grants over 100 cycles.
- Split drain: accept 0x1F0, then `s_ready=1` and `out_ready=0` for 3 cycles → `s_valid` drops after 1 cycle; no new grant while `out_valid=1`; the packet is released when `out_ready` rises and the next grant occurs on the same edge.
- Stall then burst: `out_ready=0` for 5 cycles with both inputs valid → exactly one packet held, `in*_ready=0`, `out_data` stable; on release, the order resumes with the loser first.
- Idle-skip fairness: only In0 active for 4 packets, then In1 joins → In1 wins the first contended cycle.
